// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the RV64I multi-cycle controller: FSM states,
// instruction classes, opcode and ALU command constants, alu_flags bit
// positions and branch funct3 codes.
package multicycle_control_pkg;

    // Widths are fixed by the ISA fields and the ALU command encoding.
    localparam int OPCODE_W  = 7;
    localparam int ALU_CMD_W = 4;
    localparam int FLAGS_W   = 4;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        CLS_NOP = 3'd0,
        CLS_R   = 3'd1,
        CLS_I   = 3'd2,
        CLS_LD  = 3'd3,
        CLS_SD  = 3'd4,
        CLS_BR  = 3'd5
    } instr_class_t;

    localparam logic [OPCODE_W-1:0] OPC_R   = 7'b0110011;
    localparam logic [OPCODE_W-1:0] OPC_I   = 7'b0010011;
    localparam logic [OPCODE_W-1:0] OPC_LD  = 7'b0000011;
    localparam logic [OPCODE_W-1:0] OPC_SD  = 7'b0100011;
    localparam logic [OPCODE_W-1:0] OPC_BR  = 7'b1100011;

    localparam logic [ALU_CMD_W-1:0] ALU_ADD   = 4'h0;
    localparam logic [ALU_CMD_W-1:0] ALU_SUB   = 4'h1;
    localparam logic [ALU_CMD_W-1:0] ALU_FUNCT = 4'hF;

    localparam int FLAG_EQ  = 0;
    localparam int FLAG_LT  = 1;
    localparam int FLAG_LTU = 2;
    localparam int FLAG_OVF = 3;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Opcode to instruction class; anything unsupported becomes a NOP.
    function automatic instr_class_t classify(input logic [OPCODE_W-1:0] opcode);
        instr_class_t cls;
        case (opcode)
            OPC_R:   cls = CLS_R;
            OPC_I:   cls = CLS_I;
            OPC_LD:  cls = CLS_LD;
            OPC_SD:  cls = CLS_SD;
            OPC_BR:  cls = CLS_BR;
            default: cls = CLS_NOP;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control bus between the multi-cycle controller (master) and the RV64I
// datapath (slave): instruction fields and ALU flags in, strobes out.
interface multicycle_control_if;
    import multicycle_control_pkg::*;

    logic [OPCODE_W-1:0]  opcode;
    logic [2:0]           funct3;
    logic [FLAGS_W-1:0]   alu_flags;
    logic                 ir_we;
    logic                 pc_we;
    logic                 pc_src;
    logic                 alu_src;
    logic [ALU_CMD_W-1:0] alu_cmd;
    logic                 rf_we;
    logic                 rf_src;
    logic                 d_mem_we;
    logic                 finished;
    logic                 illegal;

    modport master (
        input  opcode, funct3, alu_flags,
        output ir_we, pc_we, pc_src, alu_src, alu_cmd,
               rf_we, rf_src, d_mem_we, finished, illegal
    );

    modport slave (
        output opcode, funct3, alu_flags,
        input  ir_we, pc_we, pc_src, alu_src, alu_cmd,
               rf_we, rf_src, d_mem_we, finished, illegal
    );

endinterface

// File: rtl/multicycle_control_branch_resolve.sv
// Branch condition evaluation: funct3 selects the comparison applied to the
// ALU flags of the SUB performed in EXEC. valid is low for funct3 codes that
// have no RV64I branch meaning (010, 011).
module multicycle_control_branch_resolve
    import multicycle_control_pkg::*;
(
    input  logic [2:0]         funct3,
    input  logic [FLAGS_W-1:0] alu_flags,
    output logic               taken,
    output logic               valid
);

    // Overflow plays no part in branch decisions.
    logic flags_unused;
    assign flags_unused = alu_flags[FLAG_OVF];

    // Map funct3 onto the equal / signed-less / unsigned-less flags.
    always_comb begin
        taken = 1'b0;
        valid = 1'b1;
        case (funct3)
            F3_BEQ:  taken =  alu_flags[FLAG_EQ];
            F3_BNE:  taken = ~alu_flags[FLAG_EQ];
            F3_BLT:  taken =  alu_flags[FLAG_LT];
            F3_BGE:  taken = ~alu_flags[FLAG_LT];
            F3_BLTU: taken =  alu_flags[FLAG_LTU];
            F3_BGEU: taken = ~alu_flags[FLAG_LTU];
            default: valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle control FSM for the RV64I datapath. Each instruction walks
// FETCH -> DECODE -> EXEC -> [MEM] -> [WB]; finished pulses on retirement.
// Optional macro MULTICYCLE_CTRL_HALT_ON_ILLEGAL_EN: when defined, an illegal
// decode parks the FSM in HALT until reset instead of retiring it as a NOP.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int MEM_WAIT_CYCLES = 1
)
(
    input  logic                 clk,
    input  logic                 rst_n,
    multicycle_control_if.master bus
);

    localparam int CNT_W = (MEM_WAIT_CYCLES > 1) ? $clog2(MEM_WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_WAIT_CYCLES - 1);

    state_t         state_q, state_d;
    instr_class_t   cls_q, cls_d;
    logic [2:0]     funct3_q, funct3_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic           illegal_q, illegal_d;

    logic [2:0]     br_funct3;
    logic           br_taken;
    logic           br_valid;

    // DECODE validates the live funct3; EXEC resolves on the latched copy.
    assign br_funct3 = (state_q == ST_DECODE) ? bus.funct3 : funct3_q;

    multicycle_control_branch_resolve u_branch_resolve (
        .funct3    (br_funct3),
        .alu_flags (bus.alu_flags),
        .taken     (br_taken),
        .valid     (br_valid)
    );

    // State, latched instruction class, MEM wait counter and sticky illegal flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_FETCH;
            cls_q     <= CLS_NOP;
            funct3_q  <= 3'b000;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cls_q     <= cls_d;
            funct3_q  <= funct3_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
        end
    end

    // Next-state and Moore strobe decode from state and the latched class.
    always_comb begin
        state_d      = state_q;
        cls_d        = cls_q;
        funct3_d     = funct3_q;
        cnt_d        = cnt_q;
        illegal_d    = illegal_q;
        bus.ir_we    = 1'b0;
        bus.pc_we    = 1'b0;
        bus.pc_src   = 1'b0;
        bus.alu_src  = 1'b0;
        bus.alu_cmd  = ALU_ADD;
        bus.rf_we    = 1'b0;
        bus.rf_src   = 1'b0;
        bus.d_mem_we = 1'b0;
        bus.finished = 1'b0;

        case (state_q)
            ST_FETCH: begin
                bus.ir_we = 1'b1;
                state_d   = ST_DECODE;
            end
            ST_DECODE: begin
                funct3_d = bus.funct3;
                cls_d    = classify(bus.opcode);
                if (cls_d == CLS_BR && !br_valid) begin
                    cls_d = CLS_NOP;
                end
                if (cls_d == CLS_NOP) begin
                    illegal_d = 1'b1;
`ifdef MULTICYCLE_CTRL_HALT_ON_ILLEGAL_EN
                    state_d   = ST_HALT;
`else
                    state_d   = ST_EXEC;
`endif
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                case (cls_q)
                    CLS_R, CLS_I: begin
                        bus.alu_cmd = ALU_FUNCT;
                        bus.alu_src = (cls_q == CLS_I);
                        state_d     = ST_WB;
                    end
                    CLS_LD, CLS_SD: begin
                        bus.alu_cmd = ALU_ADD;
                        bus.alu_src = 1'b1;
                        cnt_d       = CNT_LOAD;
                        state_d     = ST_MEM;
                    end
                    CLS_BR: begin
                        bus.alu_cmd  = ALU_SUB;
                        bus.pc_src   = br_taken;
                        bus.pc_we    = 1'b1;
                        bus.finished = 1'b1;
                        state_d      = ST_FETCH;
                    end
                    default: begin
                        bus.pc_we    = 1'b1;
                        bus.finished = 1'b1;
                        state_d      = ST_FETCH;
                    end
                endcase
            end
            ST_MEM: begin
                // Keep the address computation steady while memory is busy.
                bus.alu_cmd  = ALU_ADD;
                bus.alu_src  = 1'b1;
                bus.d_mem_we = (cls_q == CLS_SD);
                if (cnt_q == '0) begin
                    if (cls_q == CLS_SD) begin
                        bus.pc_we    = 1'b1;
                        bus.finished = 1'b1;
                        state_d      = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_WB: begin
                bus.rf_we    = 1'b1;
                bus.rf_src   = (cls_q == CLS_LD);
                bus.pc_we    = 1'b1;
                bus.finished = 1'b1;
                state_d      = ST_FETCH;
            end
`ifdef MULTICYCLE_CTRL_HALT_ON_ILLEGAL_EN
            ST_HALT: begin
                state_d = ST_HALT;
            end
`endif
            default: begin
                state_d = ST_FETCH;
            end
        endcase

        // Reset forces every strobe low in the same cycle, even while the
        // state register already reads FETCH.
        if (!rst_n) begin
            bus.ir_we    = 1'b0;
            bus.pc_we    = 1'b0;
            bus.pc_src   = 1'b0;
            bus.alu_src  = 1'b0;
            bus.alu_cmd  = ALU_ADD;
            bus.rf_we    = 1'b0;
            bus.rf_src   = 1'b0;
            bus.d_mem_we = 1'b0;
            bus.finished = 1'b0;
        end
    end

    assign bus.illegal = illegal_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: instructions and their expected retirement
// behaviour are queued, then replayed one at a time while the strobes are
// observed each cycle and compared against the queued expectation.
module tb_multicycle_control;

    localparam int W = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    logic ill_model = 1'b0;

    always #5 clk = ~clk;

    multicycle_control_if bus();

    multicycle_control #(.MEM_WAIT_CYCLES(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        string      name;
        logic [6:0] op;
        logic [2:0] f3;
        logic [3:0] fl;
        logic       legal;
        logic       halts;
        logic       chk_alu;
        int         lat;
        int         rfwe_n;
        int         dm_n;
        logic       rf_src;
        logic       pc_src;
        logic       alu_src;
        logic [3:0] alu_cmd;
    } item_t;

    item_t sbq[$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic br_taken(input logic [2:0] f3, input logic [3:0] fl);
        case (f3)
            3'b000:  return fl[0];
            3'b001:  return !fl[0];
            3'b100:  return fl[1];
            3'b101:  return !fl[1];
            3'b110:  return fl[2];
            default: return !fl[2];
        endcase
    endfunction

    task automatic push_instr(input string name, input logic [6:0] op, input logic [2:0] f3,
                              input logic [3:0] fl);
        item_t e;
        e.name = name; e.op = op; e.f3 = f3; e.fl = fl;
        e.legal = 1'b1; e.halts = 1'b0; e.chk_alu = 1'b1;
        e.lat = 0; e.rfwe_n = 0; e.dm_n = 0;
        e.rf_src = 1'b0; e.pc_src = 1'b0; e.alu_src = 1'b0; e.alu_cmd = 4'h0;
        case (op)
            7'b0110011: begin e.lat = 4; e.rfwe_n = 1; e.alu_cmd = 4'hF; end
            7'b0010011: begin e.lat = 4; e.rfwe_n = 1; e.alu_cmd = 4'hF; e.alu_src = 1'b1; end
            7'b0000011: begin e.lat = 4 + W; e.rfwe_n = 1; e.rf_src = 1'b1; e.alu_src = 1'b1; end
            7'b0100011: begin e.lat = 3 + W; e.dm_n = W; e.alu_src = 1'b1; end
            7'b1100011: begin
                e.lat = 3; e.alu_cmd = 4'h1;
                if (f3 == 3'b010 || f3 == 3'b011) e.legal = 1'b0;
                else e.pc_src = br_taken(f3, fl);
            end
            default: e.legal = 1'b0;
        endcase
        if (!e.legal) begin
            e.chk_alu = 1'b0; e.lat = 3; e.rfwe_n = 0; e.dm_n = 0;
            e.rf_src = 1'b0; e.pc_src = 1'b0;
`ifdef MULTICYCLE_CTRL_HALT_ON_ILLEGAL_EN
            e.halts = 1'b1; e.lat = 0;
`endif
        end
        sbq.push_back(e);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        ill_model = 1'b0;
    endtask

    function automatic logic [12:0] all_outs();
        return {bus.ir_we, bus.pc_we, bus.pc_src, bus.alu_src, bus.alu_cmd,
                bus.rf_we, bus.rf_src, bus.d_mem_we, bus.finished, bus.illegal};
    endfunction

    // Pop one expectation, present its instruction and observe until it retires.
    task automatic run_one();
        item_t e;
        int    bound, fin_cyc, ir_n, pcwe_n, rfwe_n, dm_n, early_n, stray_n;
        logic  pcsrc_fin, alu_src3, rfsrc_wb;
        logic [3:0] alu_cmd3;
        e = sbq.pop_front();
        bus.opcode = e.op; bus.funct3 = e.f3; bus.alu_flags = e.fl;
        bound = e.halts ? 100 : 40;
        fin_cyc = 0; ir_n = 0; pcwe_n = 0; rfwe_n = 0; dm_n = 0; early_n = 0; stray_n = 0;
        pcsrc_fin = 1'b0; alu_src3 = 1'b0; rfsrc_wb = 1'b0; alu_cmd3 = 4'h0;
        for (int c = 1; c <= bound; c++) begin
            @(negedge clk);
            ir_n   += int'(bus.ir_we);
            pcwe_n += int'(bus.pc_we);
            rfwe_n += int'(bus.rf_we);
            dm_n   += int'(bus.d_mem_we);
            if (c <= 2 && (bus.rf_we || bus.d_mem_we || bus.pc_we)) early_n++;
            if (c == 3) begin alu_src3 = bus.alu_src; alu_cmd3 = bus.alu_cmd; end
            if (bus.rf_we) rfsrc_wb = bus.rf_src;
            if (bus.finished) begin
                fin_cyc = c; pcsrc_fin = bus.pc_src;
                break;
            end else if (bus.pc_src) begin
                stray_n++;
            end
        end
        if (!e.legal) ill_model = 1'b1;
        check_val({e.name, " latency"}, fin_cyc, e.lat);
        check_val({e.name, " ir_we count"}, ir_n, 1);
        check_val({e.name, " pc_we count"}, pcwe_n, e.halts ? 0 : 1);
        check_val({e.name, " rf_we count"}, rfwe_n, e.rfwe_n);
        check_val({e.name, " d_mem_we count"}, dm_n, e.dm_n);
        check_val({e.name, " early write strobe"}, early_n, 0);
        check_val({e.name, " stray pc_src"}, stray_n, 0);
        check_val({e.name, " pc_src at retire"}, pcsrc_fin, e.pc_src);
        check_val({e.name, " rf_src in WB"}, rfsrc_wb, e.rf_src);
        check_val({e.name, " illegal"}, bus.illegal, ill_model);
        if (e.chk_alu) begin
            check_val({e.name, " alu_src EXEC"}, alu_src3, e.alu_src);
            check_val({e.name, " alu_cmd EXEC"}, alu_cmd3, e.alu_cmd);
        end
        // A halted or lost FSM is brought back to FETCH alignment by reset.
        if (e.halts || fin_cyc == 0) begin
            do_reset();
            check_val({e.name, " illegal after reset"}, bus.illegal, 1'b0);
        end
    endtask

    task automatic drain();
        while (sbq.size() > 0) run_one();
    endtask

    initial begin
        logic [6:0] ops [5];
        logic [2:0] bf3 [6];
        int k;
        ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011};
        bf3 = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111};
        bus.opcode = 7'b0110011; bus.funct3 = 3'b000; bus.alu_flags = 4'b0000;

        // Reset state.
        repeat (2) @(negedge clk);
        check_val("reset outputs", all_outs(), 13'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset in the middle of an ADD's EXEC cycle.
        repeat (3) @(negedge clk);
        check_val("pre-reset alu_cmd", bus.alu_cmd, 4'hF);
        #1 rst_n = 1'b0;
        #1 check_val("reset mid-EXEC outputs", all_outs(), 13'd0);
        @(posedge clk);
        #1 check_val("reset held outputs", all_outs(), 13'd0);
        #1 rst_n = 1'b1;

        push_instr("ADD after reset", 7'b0110011, 3'b000, 4'b0000);
        push_instr("ADD", 7'b0110011, 3'b000, 4'b0000);
        push_instr("ADDI", 7'b0010011, 3'b000, 4'b0000);
        push_instr("LD", 7'b0000011, 3'b011, 4'b0000);
        push_instr("SD", 7'b0100011, 3'b011, 4'b0000);
        push_instr("BEQ", 7'b1100011, 3'b000, 4'b0001);
        push_instr("BNE", 7'b1100011, 3'b001, 4'b0001);
        push_instr("BLTU", 7'b1100011, 3'b110, 4'b0100);
        push_instr("BLT nt", 7'b1100011, 3'b100, 4'b1100);
        push_instr("BGE", 7'b1100011, 3'b101, 4'b0000);
        drain();

        push_instr("ILL opcode", 7'b1111111, 3'b000, 4'b0000);
        push_instr("ADD after ILL", 7'b0110011, 3'b000, 4'b0000);
        push_instr("ILL branch f3", 7'b1100011, 3'b010, 4'b0001);
        drain();
        do_reset();
        @(negedge clk);
        check_val("illegal cleared", bus.illegal, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            k = $urandom_range(0, 4);
            if (k == 4)
                push_instr($sformatf("rnd%0d BR", i), ops[k], bf3[$urandom_range(0, 5)],
                           4'($urandom_range(0, 15)));
            else
                push_instr($sformatf("rnd%0d op%0d", i, k), ops[k], 3'($urandom_range(0, 7)),
                           4'($urandom_range(0, 15)));
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
